// File: rtl/video_deser.sv
// Serial video receiver: frames '166 pixel bits into bytes using the sync pulses
// and queues {data, x, y} words in a small valid/ready FIFO.
module video_deser #(
    parameter int WORDS_PER_LINE = 64,
    parameter int LINES          = 342,
    parameter int H_SKIP         = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       n_clr,
    input  logic       video,
    input  logic       n_hsync,
    input  logic       n_vsync,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [7:0] out_x,
    output logic [9:0] out_y,
    output logic       frame_done,
    output logic       overrun,
    output logic [2:0] dbg_state
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  X_LAST    = 8'(WORDS_PER_LINE - 1);
    localparam logic [10:0] LINE_END  = 11'(LINES);
    localparam logic [11:0] SKIP_LAST = (H_SKIP == 0) ? 12'd0 : 12'(H_SKIP - 1);
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        WAIT_VSYNC = 3'd0,
        WAIT_LINE  = 3'd1,
        SKIP       = 3'd2,
        ACTIVE     = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam state_t LINE_START = (H_SKIP == 0) ? ACTIVE : SKIP;

    state_t      state_q;
    logic        hs_prev_q;
    logic        vs_prev_q;
    logic [6:0]  shift_q;
    logic [2:0]  bit_q;
    logic [7:0]  x_q;
    logic [9:0]  y_q;
    logic [11:0] skip_q;
    logic        frame_done_q;

    logic        hs_fall;
    logic        vs_fall;
    logic        byte_done;
    logic        line_last;
    logic [7:0]  byte_data;
    logic [10:0] y_next;

    assign hs_fall   = hs_prev_q & ~n_hsync;
    assign vs_fall   = vs_prev_q & ~n_vsync;
    assign y_next    = {1'b0, y_q} + 11'd1;
    assign line_last = (y_next == LINE_END);
    assign byte_data = {shift_q, video};
    // A sync fall on the completing edge wins: that byte is discarded, never pushed.
    assign byte_done = (state_q == ACTIVE) & ~vs_fall & ~hs_fall & (bit_q == 3'd7);

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state_q      <= WAIT_VSYNC;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            shift_q      <= '0;
            bit_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            skip_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            hs_prev_q    <= n_hsync;
            vs_prev_q    <= n_vsync;
            frame_done_q <= 1'b0;
            if (vs_fall) begin
                y_q     <= '0;
                x_q     <= '0;
                bit_q   <= '0;
                state_q <= WAIT_LINE;
            end else begin
                case (state_q)
                    WAIT_LINE: begin
                        if (hs_fall) begin
                            skip_q  <= '0;
                            x_q     <= '0;
                            bit_q   <= '0;
                            state_q <= LINE_START;
                        end
                    end
                    SKIP, ACTIVE: begin
                        if (hs_fall) begin
                            // Short line: keep what was pushed, move on to the next line.
                            skip_q <= '0;
                            x_q    <= '0;
                            bit_q  <= '0;
                            if (line_last) begin
                                state_q <= DONE;
                            end else begin
                                y_q     <= y_next[9:0];
                                state_q <= LINE_START;
                            end
                        end else if (state_q == SKIP) begin
                            if (skip_q == SKIP_LAST) begin
                                state_q <= ACTIVE;
                            end else begin
                                skip_q <= skip_q + 12'd1;
                            end
                        end else begin
                            shift_q <= byte_data[6:0];
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                if (x_q == X_LAST) begin
                                    x_q <= '0;
                                    if (line_last) begin
                                        frame_done_q <= 1'b1;
                                        state_q      <= DONE;
                                    end else begin
                                        y_q     <= y_next[9:0];
                                        state_q <= WAIT_LINE;
                                    end
                                end else begin
                                    x_q <= x_q + 8'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output handshake: an entry transfers on a rising clk edge where out_valid
    // and out_ready are both high; out_valid never depends on out_ready, and the
    // head entry is held stable until it transfers.
    logic [25:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          overrun_q;
    logic          overrun_d;
    logic          full;
    logic          pop;
    logic          do_wr;

    assign full  = (cnt_q == FULL_CNT);
    assign pop   = out_valid & out_ready;
    assign do_wr = byte_done & (~full | pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_wr && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        overrun_d = overrun_q | (byte_done & full & ~pop);
    end

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_wr) begin
                mem_q[wr_q] <= {byte_data, x_q, y_q};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid                   = (cnt_q != '0);
    assign {out_data, out_x, out_y}    = mem_q[rd_q];
    assign frame_done                  = frame_done_q;
    assign overrun                     = overrun_q;
    assign dbg_state                   = state_q;

endmodule
